serial_word_receiver: RTL

Serial-in, parallel-out receiver: the receiving end of the shifted bit stream produced by the team's parallel-load shift register. It samples one bit per enabled clock and aligns words on a frame-start marker. Each completed SHIFT_WIDTH-bit word is presented on a valid/ready output register. Overrun and framing errors are flagged as sticky status.

---
 rtl/serial_word_receiver.sv | 93 +++++++++
 1 files changed

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: serial-in/parallel-out word receiver aligned on a frame-start marker.
//   clk, aclr_n (async active-low reset), sclr (sync clear)
//   en, shiftin, frame_start : bit strobe, serial bit, word-start marker
//   q, q_valid, q_ready      : word output register with valid/ready handshake
//   busy, overrun, frame_err : partial word in flight, sticky drop, sticky mid-word restart
module serial_word_receiver #(
   parameter int    SHIFT_WIDTH     = 8,
   parameter string SHIFT_DIRECTION = "LEFT"
) (
   input  logic                   clk,
   input  logic                   aclr_n,
   input  logic                   sclr,
   input  logic                   en,
   input  logic                   shiftin,
   input  logic                   frame_start,
   input  logic                   q_ready,
   output logic [SHIFT_WIDTH-1:0] q,
   output logic                   q_valid,
   output logic                   busy,
   output logic                   overrun,
   output logic                   frame_err
);
   localparam int W  = SHIFT_WIDTH;
   localparam int CW = $clog2(W + 1);
   localparam bit LEFT = (SHIFT_DIRECTION == "LEFT");
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t         state_q, state_d;
   logic [W-1:0]   sr_q, sr_d, q_q, q_d, shifted, fresh, word;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           q_valid_q, q_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic           restart, shift_bit, done;
   // fresh is the register image after capturing only bit 0 (partial word discarded)
   if (W == 1) begin : g_one
      assign shifted = shiftin;
      assign fresh   = shiftin;
   end else begin : g_many
      assign shifted = LEFT ? {sr_q[W-2:0], shiftin} : {shiftin, sr_q[W-1:1]};
      assign fresh   = LEFT ? {{(W-1){1'b0}}, shiftin} : {shiftin, {(W-1){1'b0}}};
   end
   assign restart   = en && frame_start;
   assign shift_bit = en && !frame_start && state_q == SHIFT;
   // a one-bit word completes on its own frame_start bit
   assign done      = (restart && W == 1) || (shift_bit && cnt_q == CW'(W - 1));
   assign word      = restart ? fresh : shifted;
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         q_q         <= '0;
         q_valid_q   <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else if (sclr) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         q_q         <= '0;
         q_valid_q   <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         q_q         <= q_d;
         q_valid_q   <= q_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (done)
         state_d = IDLE;
      else if (restart)
         state_d = SHIFT;
   end
   always_comb begin
      sr_d        = restart ? fresh : shift_bit ? shifted : sr_q;
      cnt_d       = done ? '0 : restart ? CW'(1) : shift_bit ? cnt_q + CW'(1) : cnt_q;
      q_d         = (done && (!q_valid_q || q_ready)) ? word : q_q;
      // a completed word keeps valid high; otherwise a handshake drains it
      q_valid_d   = done || (q_valid_q && !q_ready);
      overrun_d   = overrun_q || (done && q_valid_q && !q_ready);
      frame_err_d = frame_err_q || (restart && state_q == SHIFT);
   end
   assign q         = q_q;
   assign q_valid   = q_valid_q;
   assign busy      = state_q == SHIFT;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
endmodule
